// File: rtl/mem_port_arbiter.sv
// Round-robin fetch / load-store arbiter for the shared 1 KiB word memory.
// One grant at a time: IDLE -> ACCESS -> RESP; address errors skip ACCESS.
module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_out,
  output logic        busy
);
  // state  | meaning
  // IDLE   | no access in flight; arbitrates and latches the winner
  // ACCESS | memory strobes driven for the latched access
  // RESP   | one-cycle ack to the grantee
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic [31:0] LAST_LEGAL = 32'(MEM_BYTES - 4);

  logic [1:0]  state_q, state_d;
  logic        port_q, port_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        grant_port;
  logic [31:0] sel_addr;
  logic        sel_err;
  logic        in_access;
  logic        in_resp;

  always_comb begin
    if (i_req && d_req) begin
      grant_port = ~last_grant_q;
    end else begin
      grant_port = d_req ? PORT_DATA : PORT_FETCH;
    end
    sel_addr = (grant_port == PORT_DATA) ? d_addr : i_addr;
    sel_err  = (sel_addr > LAST_LEGAL) || (CHECK_ALIGN && (sel_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          port_d       = grant_port;
          last_grant_d = grant_port;
          addr_d       = sel_addr;
          we_d         = (grant_port == PORT_DATA) && d_we;
          wdata_d      = (grant_port == PORT_DATA) ? d_wdata : 32'd0;
          err_d        = sel_err;
          rdata_d      = 32'd0;
          state_d      = sel_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          rdata_d = mem_out;
        end
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      port_q       <= PORT_FETCH;
      last_grant_q <= PORT_FETCH;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset kills a pending write at once.
  assign in_access = (state_q == S_ACCESS);
  assign in_resp   = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);

  assign mem_address    = in_access ? addr_q  : 32'd0;
  assign mem_write_data = in_access ? wdata_q : 32'd0;
  assign mem_read       = in_access && !we_q;
  assign mem_write      = in_access && we_q;

  assign i_ack   = in_resp && (port_q == PORT_FETCH);
  assign d_ack   = in_resp && (port_q == PORT_DATA);
  assign i_rdata = i_ack ? rdata_q : 32'd0;
  assign d_rdata = d_ack ? rdata_q : 32'd0;
  assign i_err   = i_ack && err_q;
  assign d_err   = d_ack && err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester controller for the shared byte-addressed, 1 KiB, little-endian-write word memory used by the multi-cycle core.
- Requesters: instruction fetch (read-only) and load/store (read/write).
- Grants one word access at a time round-robin, sequences the memory's read/write strobes, and captures read data.
- Returns the result with a one-cycle ack, plus an error flag for illegal addresses.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; legal word addresses are 0..MEM_BYTES-4.
- CHECK_ALIGN, 1, when 1, addr[1:0]!=0 is an error; when 0, unaligned addresses are allowed.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle completion pulse to fetch.
- i_rdata  out  32  fetch read data, valid while i_ack=1.
- i_err  out  1  fetch address error, valid while i_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1=write, 0=read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle completion pulse to data port.
- d_rdata  out  32  load data, valid while d_ack=1.
- d_err  out  1  data address error, valid while d_ack=1.
- mem_address  out  32  to memory address.
- mem_write_data  out  32  to memory write_data.
- mem_read  out  1  to memory read strobe.
- mem_write  out  1  to memory write strobe; the memory writes on posedge while high.
- mem_out  in  32  memory combinational read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Async reset -> IDLE.
- Reset values: all outputs 0, last_grant=FETCH, so data wins the first contention.
- IDLE:
  - If no req: stay.
  - If exactly one req: grant it.
  - If both req: grant the port not equal to last_grant.
  - On grant, latch port id, addr, we (forced 0 for fetch) and wdata, and update last_grant.
  - Compute err: (addr > MEM_BYTES-4) or (CHECK_ALIGN and addr[1:0]!=0).
  - err=0 -> ACCESS; err=1 -> RESP, no memory access, rdata=0.
- ACCESS, one cycle:
  - mem_address = latched addr; mem_write_data = latched wdata.
  - mem_read = ~we; mem_write = we.
  - On a read, capture mem_out into the rdata register at the end of the cycle. On a write, the memory commits at the same edge.
  - Next state: RESP.
- RESP, one cycle:
  - Pulse the grantee's ack with rdata and err.
  - The non-granted ack stays 0; the non-granted rdata/err are don't-care but driven 0.
  - Write ack returns rdata=0. Next state: IDLE.
- mem_read and mem_write are decoded from the state and are 0 outside ACCESS. mem_address and mem_write_data are 0 outside ACCESS.
- Latency, with the request sampled in an IDLE cycle t: legal access acks at t+2; error acks at t+1. Back-to-back throughput is one access per 3 cycles.
- Handshake:
  - A requester must keep req, addr, we and wdata stable until ack. The block ignores changes after the grant.
  - req still high in the cycle after ack is treated as a new request.
  - Dropping req before ack is illegal and its result is undefined, but the FSM still completes and acks.
- A waiting requester is never starved: with both requests held continuously, grants alternate D, I, D, I...
- Reset mid-operation:
  - Asserting rst_n low in ACCESS immediately clears mem_write and mem_read; a write not yet clocked is not performed.
  - Any pending ack is lost and the FSM returns to IDLE.
- Width rules: address compare is unsigned 32-bit. Address MEM_BYTES-4 is legal; MEM_BYTES-3 and above are errors.

Test Plan:
- Data write then read: d_we=1, d_addr=0x10, d_wdata=0xA1B2C3D4 -> d_ack at t+2, mem_write high exactly 1 cycle. Then a read of 0x10 -> d_rdata=0xD4C3B2A1 per the memory's byte order, d_err=0.
- Simultaneous requests after reset, both held: first grant data, then fetch, then data. Acks alternate at cycles t+2, t+5, t+8; i_ack and d_ack are never high together.
- Error paths:
  - d_addr=0x3FD -> d_ack at t+1, d_err=1, d_rdata=0, mem_write never asserted.
  - i_addr=0x3FC -> legal.
  - CHECK_ALIGN=1 with i_addr=0x6 -> i_err=1.
- Fetch-only stream: i_req held high for 4 transactions at addresses 0, 4, 8, 12 -> 4 i_ack pulses spaced 3 cycles apart, with correct preloaded words.
- Reset during ACCESS of a write of 0xFFFFFFFF to 0x20: rst_n low mid-cycle -> mem_write drops immediately, memory word at 0x20 unchanged, all outputs 0, busy=0.
- Request change after grant: change d_wdata in the ACCESS cycle -> the originally latched value is written.
